// File: rtl/csi2_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane-alignment logic.
package csi2_rx_pkg;

  localparam int MAX_LANES = 4;

  typedef enum logic [2:0] {
    IDLE_S     = 3'd0,
    WAIT_SOT_S = 3'd1,
    CHECK_S    = 3'd2,
    ALIGNED_S  = 3'd3,
    ERR_S      = 3'd4
  } state_e;

endpackage

// File: rtl/csi2_lane_arrival.sv
// Per-lane SoT arrival recorder: captures the burst counter on the first
// sync-byte pulse of a burst and holds it until the next clear.
module csi2_lane_arrival #(
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic             sot,
  input  logic [CNT_W-1:0] cnt,
  output logic             recorded,
  output logic [CNT_W-1:0] arrival
);

  logic             recorded_reg;
  logic [CNT_W-1:0] arrival_reg;

  // First SoT of the burst wins; later pulses leave the arrival untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      recorded_reg <= 1'b0;
      arrival_reg  <= '0;
    end else if (enable && sot && !recorded_reg) begin
      recorded_reg <= 1'b1;
      arrival_reg  <= cnt;
    end
  end

  assign recorded = recorded_reg;
  assign arrival  = arrival_reg;

endmodule

// File: rtl/csi2_lane_align_ctrl.sv
// CSI-2 lane alignment controller: measures per-lane SoT skew, produces
// deskew delays and a single aligned HS-active window, and flags errors.
module csi2_lane_align_ctrl
  import csi2_rx_pkg::*;
#(
  parameter  int LANES         = 2,
  parameter  int TIMEOUT_TICKS = 64,
  parameter  int MAX_SKEW      = 7,
  localparam int DLY_W         = (MAX_SKEW < 1) ? 1 : $clog2(MAX_SKEW + 1),
  localparam int CNT_W         = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             active_lanes_i,
  input  logic [LANES-1:0]       hs_data_valid_i,
  input  logic [LANES-1:0]       sot_det_i,
  output logic [LANES*DLY_W-1:0] lane_delay_o,
  output logic                   align_done_o,
  output logic                   hs_active_o,
  output logic                   err_timeout_o,
  output logic                   err_skew_o
);

  state_e               state_reg, state_next;
  logic [2:0]           act_n_reg, act_clamp;
  logic [CNT_W-1:0]     cnt_reg;
  logic [LANES-1:0]     act_mask, in_mask, recorded, hit;
  logic [CNT_W-1:0]     arrival [LANES];
  logic [CNT_W-1:0]     diff    [LANES];
  logic [CNT_W-1:0]     arr_max, arr_min, spread;
  logic                 skew_bad, all_done, any_valid, idle_start, to_timeout;
  logic                 burst_clear, wait_st;
  logic [LANES*DLY_W-1:0] lane_delay_reg;
  logic                 align_done_reg, hs_active_reg, err_timeout_reg, err_skew_reg;

  // Clamp the requested lane count into 1..LANES.
  always_comb begin
    act_clamp = active_lanes_i;
    if (active_lanes_i == 3'd0)
      act_clamp = 3'd1;
    else if (int'(active_lanes_i) > LANES)
      act_clamp = 3'(LANES);
  end

  assign wait_st     = (state_reg == WAIT_SOT_S);
  assign burst_clear = (state_reg == IDLE_S) && idle_start;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Latched mask governs the burst; the live clamp decides burst start.
      assign act_mask[gi] = (act_n_reg > 3'(gi));
      assign in_mask[gi]  = (act_clamp > 3'(gi));
      assign hit[gi]      = wait_st && act_mask[gi] && sot_det_i[gi] && !recorded[gi];
      assign diff[gi]     = arr_max - arrival[gi];

      csi2_lane_arrival #(.CNT_W(CNT_W)) u_arrival (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (burst_clear),
        .enable   (wait_st && act_mask[gi]),
        .sot      (sot_det_i[gi]),
        .cnt      (cnt_reg),
        .recorded (recorded[gi]),
        .arrival  (arrival[gi])
      );
    end
  endgenerate

  // A lane recorded this very cycle counts towards completion.
  assign all_done   = &(recorded | hit | ~act_mask);
  assign any_valid  = |(hs_data_valid_i & act_mask);
  assign idle_start = |(hs_data_valid_i & in_mask);

  // Max/min arrival over active lanes only.
  always_comb begin
    arr_max = '0;
    arr_min = '1;
    for (int i = 0; i < LANES; i++) begin
      if (act_mask[i]) begin
        if (arrival[i] > arr_max) arr_max = arrival[i];
        if (arrival[i] < arr_min) arr_min = arrival[i];
      end
    end
  end

  assign spread   = arr_max - arr_min;
  assign skew_bad = (int'(spread) > MAX_SKEW);

  // Next-state decision; completion beats timeout, timeout beats abort.
  always_comb begin
    state_next = state_reg;
    to_timeout = 1'b0;
    case (state_reg)
      IDLE_S:     if (idle_start) state_next = WAIT_SOT_S;
      WAIT_SOT_S: begin
        if (all_done) begin
          state_next = CHECK_S;
        end else if (cnt_reg == CNT_W'(TIMEOUT_TICKS - 1)) begin
          state_next = ERR_S;
          to_timeout = 1'b1;
        end else if (!any_valid) begin
          state_next = IDLE_S;
        end
      end
      CHECK_S:    state_next = skew_bad ? ERR_S : ALIGNED_S;
      ALIGNED_S:  if (!any_valid) state_next = IDLE_S;
      ERR_S:      if (!any_valid) state_next = IDLE_S;
      default:    state_next = IDLE_S;
    endcase
  end

  // State, burst counter, lane-count latch and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE_S;
      act_n_reg       <= 3'd1;
      cnt_reg         <= '0;
      lane_delay_reg  <= '0;
      align_done_reg  <= 1'b0;
      hs_active_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_skew_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (burst_clear) begin
        act_n_reg <= act_clamp;
        cnt_reg   <= '0;
      end else if (wait_st) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == CHECK_S && !skew_bad) begin
        for (int i = 0; i < LANES; i++)
          lane_delay_reg[i*DLY_W +: DLY_W] <= act_mask[i] ? diff[i][DLY_W-1:0] : '0;
      end
      align_done_reg  <= (state_reg == CHECK_S) && !skew_bad;
      err_skew_reg    <= (state_reg == CHECK_S) && skew_bad;
      err_timeout_reg <= to_timeout;
      // Window stays up for the IDLE cycle right after the burst ends.
      hs_active_reg   <= (state_next == ALIGNED_S) || (state_reg == ALIGNED_S);
    end
  end

  assign lane_delay_o  = lane_delay_reg;
  assign align_done_o  = align_done_reg;
  assign hs_active_o   = hs_active_reg;
  assign err_timeout_o = err_timeout_reg;
  assign err_skew_o    = err_skew_reg;

endmodule

// File: tb/tb_csi2_lane_align_ctrl.sv
// Scoreboard bench for csi2_lane_align_ctrl (LANES=4, TIMEOUT_TICKS=64, MAX_SKEW=7).
module tb_csi2_lane_align_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  act;
  logic [3:0]  vld;
  logic [3:0]  sot;
  logic [11:0] dly;
  logic        done, hsa, eto, esk;

  csi2_lane_align_ctrl #(
    .LANES         (4),
    .TIMEOUT_TICKS (64),
    .MAX_SKEW      (7)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .active_lanes_i  (act),
    .hs_data_valid_i (vld),
    .sot_det_i       (sot),
    .lane_delay_o    (dly),
    .align_done_o    (done),
    .hs_active_o     (hsa),
    .err_timeout_o   (eto),
    .err_skew_o      (esk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulses = {align_done, err_timeout, err_skew}
  typedef struct {
    logic [2:0]  pulses;
    int          at;
    logic [11:0] dly;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done || eto || esk)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'({done, eto, esk}), 64'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", 64'({done, eto, esk}), 64'(e.pulses));
        check("event_cycle", 64'(cyc), 64'(e.at));
        check("lane_delay", 64'(dly), 64'(e.dly));
        check("hs_active_at_event", 64'(hsa), 64'(e.pulses == 3'b100));
      end
      $display("event cycle=%0d done=%0b timeout=%0b skew=%0b delay=0x%03h hs_active=%0b",
               cyc, done, eto, esk, dly, hsa);
    end
  end

  // One burst: k = SoT cycle offsets from E (-1 = never), off = expected pulse offset.
  task automatic run_burst(input logic [2:0] a, input logic [3:0] vm,
                           input int k0, input int k1, input int k2, input int k3,
                           input int dup0, input int abort_at,
                           input logic [2:0] exp_p, input int off,
                           input logic [11:0] exp_d, input bit do_rst);
    int e;
    int k[4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    @(posedge clk); #1;
    act = a; vld = vm; sot = '0;
    e = cyc + 1;
    if (exp_p != 3'b000) sb.push_back('{pulses: exp_p, at: e + off, dly: exp_d});
    for (int t = 0; t < 70; t++) begin
      @(posedge clk); #1;
      sot = '0;
      for (int i = 0; i < 4; i++) if (k[i] == t) sot[i] = 1'b1;
      if (dup0 == t) sot[0] = 1'b1;
      if (abort_at == t) vld = '0;
    end
    // Stray SoTs after the decision must be ignored.
    @(posedge clk); #1; sot = 4'hF;
    @(posedge clk); #1; sot = '0;
    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    check("pending_events", 64'(sb.size()), 64'd0);
    sb.delete();
    check("hs_active_hold", 64'(hsa), 64'(exp_p == 3'b100 && abort_at < 0));
    if (do_rst) begin
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; vld = '0;
      check("rst_hs_active", 64'(hsa), 64'd0);
      check("rst_lane_delay", 64'(dly), 64'd0);
      check("rst_pulses", 64'({done, eto, esk}), 64'd0);
    end else begin
      @(posedge clk); #1; vld = '0;
      @(posedge clk); #1;
      check("hs_active_tail", 64'(hsa), 64'(exp_p == 3'b100 && abort_at < 0));
      @(posedge clk); #1;
      check("hs_active_fall", 64'(hsa), 64'd0);
    end
    repeat (3) @(posedge clk);
    $display("burst act=%0d k={%0d,%0d,%0d,%0d} done checks=%0d errors=%0d",
             a, k0, k1, k2, k3, checks, errors);
  endtask

  initial begin
    rst = 1'b1; act = 3'd2; vld = '0; sot = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lane_delay", 64'(dly), 64'd0);
    check("reset_hs_active", 64'(hsa), 64'd0);
    check("reset_pulses", 64'({done, eto, esk}), 64'd0);
    rst = 1'b0;

    // 2 lanes, SoT at 3 and 5: lane0 delay 2.
    run_burst(3'd2, 4'b0011, 3, 5, -1, -1, -1, -1, 3'b100, 7, 12'h002, 1'b0);
    // 4 lanes, SoTs 0,7,2,7: delays {0,5,0,7} lane3..0.
    run_burst(3'd4, 4'b1111, 0, 7, 2, 7, -1, -1, 3'b100, 9, 12'h147, 1'b0);
    // Spread 8: skew error, delays unchanged.
    run_burst(3'd4, 4'b1111, 0, 8, 2, 7, -1, -1, 3'b001, 10, 12'h147, 1'b0);
    // Only lane0 SoTs: timeout pulse at E+64.
    run_burst(3'd2, 4'b0011, 3, -1, -1, -1, -1, -1, 3'b010, 64, 12'h147, 1'b0);
    // Last SoT at k=63 still aligns.
    run_burst(3'd2, 4'b0011, 60, 63, -1, -1, -1, -1, 3'b100, 65, 12'h003, 1'b0);
    // One active lane, lane1 valid but silent.
    run_burst(3'd1, 4'b0011, 4, -1, -1, -1, -1, -1, 3'b100, 6, 12'h000, 1'b0);
    // Silent abort mid WAIT_SOT, then a normal burst.
    run_burst(3'd2, 4'b0011, 2, -1, -1, -1, -1, 5, 3'b000, 0, 12'h000, 1'b0);
    run_burst(3'd2, 4'b0011, 1, 2, -1, -1, -1, -1, 3'b100, 4, 12'h001, 1'b0);
    // Duplicate lane0 SoTs at 4 must not move its arrival from 2.
    run_burst(3'd2, 4'b0011, 2, 6, -1, -1, 4, -1, 3'b100, 8, 12'h004, 1'b0);
    // Lane count 0 clamps to 1, 7 clamps to 4.
    run_burst(3'd0, 4'b0011, 2, -1, -1, -1, -1, -1, 3'b100, 4, 12'h000, 1'b0);
    run_burst(3'd7, 4'b1111, 1, 1, 1, 3, -1, -1, 3'b100, 5, 12'h092, 1'b0);
    // Reset while ALIGNED, then a fresh burst.
    run_burst(3'd2, 4'b0011, 0, 1, -1, -1, -1, -1, 3'b100, 3, 12'h001, 1'b1);
    run_burst(3'd2, 4'b0011, 3, 1, -1, -1, -1, -1, 3'b100, 5, 12'h010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
